alu_seq_exec: RTL and testbench
===============================

// Module: alu_seq_exec
// PURPOSE
//  Sequential ALU execution unit. It is the responder side of the ALU operand/opCode interface.
//  It accepts one operation per valid/ready handshake and computes ADD in one cycle.
//  MUL (shift-add) and DIV (restoring) each take N=WIDTH+1 iterations.
//  It returns the result plus flags (negativo, cero, acarreo, desbordamiento) on a valid/ready
//  response channel. It sits between the instruction sequencer and the register-file write-back.
// PARAMETERS
//  WIDTH  31  MSB index of the data path; operands/result are WIDTH+1 bits (N=WIDTH+1)
// PORTS
//  clk             in   1        single clock; all state changes on rising edge
//  rst             in   1        synchronous, active-high reset
//  in_valid        in   1        request valid
//  in_ready        out  1        request ready (high only in IDLE)
//  a               in   N        operand A (unsigned for MUL/DIV; two's complement for ADD flags)
//  b               in   N        operand B
//  opCode          in   2        00 ADD, 01 MUL, 10 DIV, 11 reserved
//  ci              in   1        carry-in, used by ADD only
//  out_valid       out  1        response valid
//  out_ready       in   1        response ready
//  out             out  N        result
//  co              out  1        ADD carry-out; 0 for other ops
//  negativo        out  1        out[WIDTH]
//  cero            out  1        out==0
//  acarreo         out  1        see flag rules
//  desbordamiento  out  1        see flag rules
//  div_zero        out  1        DIV with b==0
// BEHAVIOUR
//  Reset: state=IDLE, in_ready=1 in the cycle after reset; every other output =0. Holds while rst=1.
//  FSM: IDLE, MUL, DIV, DONE.
//   - IDLE: accept when in_valid&in_ready at a rising edge. Operands, op and ci are latched.
//   - ADD: out = a+b+ci registered at the accept edge; goes to DONE; out_valid seen next cycle.
//   - MUL: goes to MUL with cnt=0. One partial-product iteration per edge.
//     Two's... no: the 2N-bit product is accumulated. At cnt==N-1 the FSM goes to DONE.
//     out_valid rises N edges after the accept edge.
//   - DIV, b!=0: goes to DIV. One restoring step per edge, N steps, then DONE.
//     out = unsigned quotient a/b; remainder is discarded.
//   - DIV, b==0: straight to DONE at the accept edge. out=all ones, div_zero=1, other flags per rules.
//   - opCode 11: straight to DONE at the accept edge. out=0, all flags 0 except cero=1.
//   - DONE: out_valid=1. out and flags stay stable until out_valid&out_ready at an edge, then IDLE.
//     in_ready is not asserted in the same cycle as out_valid (no overlap, max 1 op in flight).
//  Flag rules, all registered with out:
//   - ADD: acarreo=co=carry out of bit WIDTH. desbordamiento = signed overflow (operands same sign, result sign differs).
//   - MUL: out = low N bits of product. acarreo = desbordamiento = (high N bits != 0). co=0.
//   - DIV: acarreo=desbordamiento=co=0.
//   - All ops: negativo=out[WIDTH], cero=(out==0).
//  Operand inputs are ignored outside the accept edge; changing them mid-operation has no effect.
//  rst=1 mid-operation (MUL/DIV/DONE): the result is abandoned. Next cycle: IDLE, out_valid=0, outputs 0.
// TESTING (WIDTH=31)
//  1. ADD a=7, b=2, ci=0 -> 1 cycle later out=9; cero=0, acarreo=0, desbordamiento=0.
//  2. ADD a=32'hFFFFFFFF, b=1 -> out=0; cero=1, acarreo=co=1, desbordamiento=0.
//     ADD a=32'h7FFFFFFF, b=1 -> out=32'h80000000; negativo=1, desbordamiento=1.
//  3. MUL a=13, b=3 -> out_valid exactly 32 edges after accept; out=39, acarreo=0.
//     MUL a=b=32'h10000 -> out=0, cero=1, desbordamiento=1.
//  4. DIV a=13, b=3 -> after 32 edges out=4. DIV a=1, b=2 -> out=0, cero=1.
//     DIV a=5, b=0 -> next cycle out=32'hFFFFFFFF, div_zero=1.
//  5. Backpressure: hold out_ready=0 for 10 cycles after out_valid -> out/flags stable, in_ready=0.
//     Then out_ready=1 -> IDLE, in_ready=1 next cycle.
//  6. Assert rst at cnt=10 of a MUL -> next cycle out_valid=0, in_ready=1, out=0.
//     A new ADD 1+2 is then accepted and returns 3.

Source files
------------

// File: rtl/alu_seq_exec_if.sv
// Operand/opCode request channel and result/flags response channel of the sequential ALU.
// Both channels use valid/ready: a transfer happens on a rising edge where valid and ready are both high;
// the sender holds valid and its payload steady until that edge, and ready never depends on valid.
interface alu_seq_exec_if #(
    parameter int WIDTH = 31
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH:0]   a;
    logic [WIDTH:0]   b;
    logic [1:0]       opCode;
    logic             ci;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH:0]   out;
    logic             co;
    logic             negativo;
    logic             cero;
    logic             acarreo;
    logic             desbordamiento;
    logic             div_zero;

    modport slave (
        input  in_valid, a, b, opCode, ci, out_ready,
        output in_ready, out_valid, out, co, negativo, cero, acarreo, desbordamiento, div_zero
    );

    modport master (
        output in_valid, a, b, opCode, ci, out_ready,
        input  in_ready, out_valid, out, co, negativo, cero, acarreo, desbordamiento, div_zero
    );
endinterface

// File: rtl/alu_seq_exec.sv
// Sequential ALU: single-cycle ADD, shift-add MUL and restoring DIV over WIDTH+1 iterations,
// with result and flags held on a valid/ready response channel until taken.
module alu_seq_exec #(
    parameter int WIDTH = 31
) (
    input  logic               clk,
    input  logic               rst,
    alu_seq_exec_if.slave      bus,
    output logic [1:0]         o_dbg_state
);
    localparam int N  = WIDTH + 1;
    localparam int CW = $clog2(N);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_MUL = 2'd1;
    localparam logic [1:0] OP_DIV = 2'd2;

    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    logic [1:0]     r_state;
    logic [CW-1:0]  r_cnt;
    logic [2*N-1:0] r_acc;
    logic [N-1:0]   r_b;
    logic [N-1:0]   r_out;
    logic           r_co;
    logic           r_cero;
    logic           r_acarreo;
    logic           r_desb;
    logic           r_div_zero;

    logic           w_accept;
    logic           w_last;
    logic [N:0]     w_add;
    logic [N:0]     w_mul_sum;
    logic [2*N-1:0] w_mul_next;
    logic [N:0]     w_div_shift;
    logic [N-1:0]   w_div_rem;
    logic           w_div_ok;
    logic [2*N-1:0] w_div_next;

    logic           w_load;
    logic [N-1:0]   w_val;
    logic           w_co;
    logic           w_carry;
    logic           w_ovf;
    logic           w_dz;

    assign w_accept = bus.in_valid && (r_state == S_IDLE);
    assign w_last   = (r_cnt == CNT_LAST);
    assign w_add    = {1'b0, bus.a} + {1'b0, bus.b} + (N + 1)'(bus.ci);

    // Upper half of r_acc is the partial product, lower half the multiplier shifting out LSB first.
    assign w_mul_sum  = {1'b0, r_acc[2*N-1:N]} + (r_acc[0] ? {1'b0, r_b} : {(N + 1){1'b0}});
    assign w_mul_next = {w_mul_sum, r_acc[N-1:1]};

    // For DIV the upper half is the partial remainder, the lower half dividend bits becoming quotient bits.
    assign w_div_shift = {r_acc[2*N-1:N], r_acc[N-1]};
    assign w_div_ok    = (w_div_shift >= {1'b0, r_b});
    assign w_div_rem   = w_div_shift[N-1:0] - r_b;
    assign w_div_next  = w_div_ok ? {w_div_rem, r_acc[N-2:0], 1'b1}
                                  : {w_div_shift[N-1:0], r_acc[N-2:0], 1'b0};

    always_comb begin
        w_load  = 1'b0;
        w_val   = '0;
        w_co    = 1'b0;
        w_carry = 1'b0;
        w_ovf   = 1'b0;
        w_dz    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    case (bus.opCode)
                        OP_ADD: begin
                            w_load  = 1'b1;
                            w_val   = w_add[N-1:0];
                            w_co    = w_add[N];
                            w_carry = w_add[N];
                            w_ovf   = (bus.a[WIDTH] == bus.b[WIDTH]) && (w_add[WIDTH] != bus.a[WIDTH]);
                        end
                        OP_MUL: w_load = 1'b0;
                        OP_DIV: begin
                            if (bus.b == '0) begin
                                w_load = 1'b1;
                                w_val  = '1;
                                w_dz   = 1'b1;
                            end
                        end
                        default: w_load = 1'b1;
                    endcase
                end
            end
            S_MUL: begin
                if (w_last) begin
                    w_load  = 1'b1;
                    w_val   = w_mul_next[N-1:0];
                    w_carry = |w_mul_next[2*N-1:N];
                    w_ovf   = |w_mul_next[2*N-1:N];
                end
            end
            S_DIV: begin
                if (w_last) begin
                    w_load = 1'b1;
                    w_val  = w_div_next[N-1:0];
                end
            end
            default: w_load = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_acc      <= '0;
            r_b        <= '0;
            r_out      <= '0;
            r_co       <= 1'b0;
            r_cero     <= 1'b0;
            r_acarreo  <= 1'b0;
            r_desb     <= 1'b0;
            r_div_zero <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_acc <= {{N{1'b0}}, bus.a};
                        r_b   <= bus.b;
                        r_cnt <= '0;
                        if (bus.opCode == OP_MUL) begin
                            r_state <= S_MUL;
                        end else if (bus.opCode == OP_DIV && bus.b != '0) begin
                            r_state <= S_DIV;
                        end else begin
                            r_state <= S_DONE;
                        end
                    end
                end
                S_MUL: begin
                    r_acc <= w_mul_next;
                    r_cnt <= r_cnt + CW'(1);
                    if (w_last) r_state <= S_DONE;
                end
                S_DIV: begin
                    r_acc <= w_div_next;
                    r_cnt <= r_cnt + CW'(1);
                    if (w_last) r_state <= S_DONE;
                end
                default: begin
                    if (bus.out_ready) r_state <= S_IDLE;
                end
            endcase
            if (w_load) begin
                r_out      <= w_val;
                r_co       <= w_co;
                r_cero     <= (w_val == '0);
                r_acarreo  <= w_carry;
                r_desb     <= w_ovf;
                r_div_zero <= w_dz;
            end
        end
    end

    assign bus.in_ready       = (r_state == S_IDLE);
    assign bus.out_valid      = (r_state == S_DONE);
    assign bus.out            = r_out;
    assign bus.co             = r_co;
    assign bus.negativo       = r_out[WIDTH];
    assign bus.cero           = r_cero;
    assign bus.acarreo        = r_acarreo;
    assign bus.desbordamiento = r_desb;
    assign bus.div_zero       = r_div_zero;
    assign o_dbg_state        = r_state;
endmodule

// File: tb/tb_alu_seq_exec.sv
// Bench for alu_seq_exec: arithmetic reference model with an expected queue checked every cycle,
// directed literal cases, backpressure, mid-operation reset and randomized operations.
module tb_alu_seq_exec;
    typedef struct {
        logic [31:0] out;
        logic [5:0]  flags;   // {co, negativo, cero, acarreo, desbordamiento, div_zero}
        int          lat;     // edges from the accept edge to the edge raising out_valid
        int          acc;
        bit          seen;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [1:0] dbg_state;
    int         cyc;
    int         n_tests;
    int         n_fail;
    exp_t       exp_q[$];

    alu_seq_exec_if #(.WIDTH(31)) bus();

    alu_seq_exec #(.WIDTH(31)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic exp_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                   input logic ci);
        exp_t        e;
        logic [63:0] u;
        longint      s;
        logic        co, carry, ovf, dz;
        co = 1'b0; carry = 1'b0; ovf = 1'b0; dz = 1'b0;
        e.out = 32'd0;
        e.lat = 0;
        case (op)
            2'd0: begin
                u     = {32'd0, a} + {32'd0, b} + (ci ? 64'd1 : 64'd0);
                e.out = u[31:0];
                co    = u[32];
                carry = u[32];
                s     = longint'(signed'(a)) + longint'(signed'(b)) + (ci ? 64'sd1 : 64'sd0);
                ovf   = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            2'd1: begin
                u     = {32'd0, a} * {32'd0, b};
                e.out = u[31:0];
                carry = (u[63:32] != 32'd0);
                ovf   = carry;
                e.lat = 32;
            end
            2'd2: begin
                if (b == 32'd0) begin
                    e.out = 32'hFFFF_FFFF;
                    dz    = 1'b1;
                end else begin
                    e.out = a / b;
                    e.lat = 32;
                end
            end
            default: e.out = 32'd0;
        endcase
        e.flags = {co, e.out[31], (e.out == 32'd0), carry, ovf, dz};
        e.acc   = 0;
        e.seen  = 1'b0;
        return e;
    endfunction

    // Compare process: whenever a response is offered it must match the head of the expected queue.
    always @(negedge clk) begin
        if (!rst && bus.out_valid) begin
            if (exp_q.size() == 0) begin
                check("spurious_out_valid", 1, 0);
            end else begin
                if (!exp_q[0].seen) begin
                    check("latency", 64'(cyc - exp_q[0].acc), 64'(exp_q[0].lat));
                    exp_q[0].seen = 1'b1;
                end
                check("out", bus.out, exp_q[0].out);
                check("flags", {bus.co, bus.negativo, bus.cero, bus.acarreo, bus.desbordamiento,
                                bus.div_zero}, exp_q[0].flags);
                check("in_ready_during_valid", bus.in_ready, 0);
                if (bus.out_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic ci,
                         input int hold, output logic [31:0] r_out, output logic [5:0] r_flags,
                         output int lat);
        exp_t e;
        int   k;
        k = 0;
        while (!bus.in_ready && k < 100) begin
            @(posedge clk); #1; k++;
        end
        r_out = '0; r_flags = '0; lat = -1;
        if (!bus.in_ready) begin
            check("in_ready_timeout", 0, 1);
            return;
        end
        e = model(op, a, b, ci);
        e.acc = cyc + 1;
        exp_q.push_back(e);
        bus.in_valid = 1'b1;
        bus.a = a; bus.b = b; bus.opCode = op; bus.ci = ci;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.a = $urandom; bus.b = $urandom;
        bus.opCode = 2'($urandom_range(0, 3)); bus.ci = 1'($urandom_range(0, 1));
        lat = 0;
        while (!bus.out_valid && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
        if (!bus.out_valid) begin
            check("out_valid_timeout", 0, 1);
            exp_q.delete();
            return;
        end
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
        end
        r_out   = bus.out;
        r_flags = {bus.co, bus.negativo, bus.cero, bus.acarreo, bus.desbordamiento, bus.div_zero};
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        logic [5:0]  f;
        int          lat;
        logic [31:0] edge_vals [5];
        logic [31:0] ra, rb;
        edge_vals[0] = 32'd0;          edge_vals[1] = 32'd1;  edge_vals[2] = 32'hFFFF_FFFF;
        edge_vals[3] = 32'h7FFF_FFFF;  edge_vals[4] = 32'h8000_0000;
        cyc = 0; n_tests = 0; n_fail = 0;
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.opCode = '0; bus.ci = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_in_ready", bus.in_ready, 1);
        check("reset_outputs", {bus.out_valid, bus.out, bus.co, bus.negativo, bus.cero, bus.acarreo,
                                bus.desbordamiento, bus.div_zero}, 0);
        rst = 1'b0;

        do_op(2'd0, 32'd7, 32'd2, 1'b0, 0, r, f, lat);
        check("add_7_2", r, 32'd9);
        check("add_7_2_flags", f, 6'b000000);
        check("add_7_2_lat", lat, 0);
        do_op(2'd0, 32'hFFFF_FFFF, 32'd1, 1'b0, 0, r, f, lat);
        check("add_wrap", r, 32'd0);
        check("add_wrap_flags", f, 6'b101100);
        do_op(2'd0, 32'h7FFF_FFFF, 32'd1, 1'b0, 0, r, f, lat);
        check("add_ovf", r, 32'h8000_0000);
        check("add_ovf_flags", f, 6'b010010);
        do_op(2'd1, 32'd13, 32'd3, 1'b0, 0, r, f, lat);
        check("mul_13_3", r, 32'd39);
        check("mul_13_3_flags", f, 6'b000000);
        check("mul_lat", lat, 32);
        do_op(2'd1, 32'h1_0000, 32'h1_0000, 1'b0, 0, r, f, lat);
        check("mul_big", r, 32'd0);
        check("mul_big_flags", f, 6'b001110);
        do_op(2'd2, 32'd13, 32'd3, 1'b0, 0, r, f, lat);
        check("div_13_3", r, 32'd4);
        check("div_lat", lat, 32);
        do_op(2'd2, 32'd1, 32'd2, 1'b0, 0, r, f, lat);
        check("div_1_2", r, 32'd0);
        check("div_1_2_flags", f, 6'b001000);
        do_op(2'd2, 32'd5, 32'd0, 1'b0, 0, r, f, lat);
        check("div_zero_out", r, 32'hFFFF_FFFF);
        check("div_zero_flags", f, 6'b010001);
        check("div_zero_lat", lat, 0);
        do_op(2'd3, 32'd9, 32'd9, 1'b1, 0, r, f, lat);
        check("reserved", r, 32'd0);
        check("reserved_flags", f, 6'b001000);

        // Backpressure: response must stay put for 10 cycles, then ready returns right after the take.
        do_op(2'd0, 32'd100, 32'd23, 1'b1, 10, r, f, lat);
        check("bp_out", r, 32'd124);
        check("bp_in_ready_after", bus.in_ready, 1);

        // Reset in the middle of a MUL abandons it.
        bus.in_valid = 1'b1; bus.a = 32'd55; bus.b = 32'd77; bus.opCode = 2'd1; bus.ci = 1'b0;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("mid_mul_busy", bus.in_ready, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_mid_out_valid", bus.out_valid, 0);
        check("rst_mid_in_ready", bus.in_ready, 1);
        check("rst_mid_out", bus.out, 0);
        do_op(2'd0, 32'd1, 32'd2, 1'b0, 0, r, f, lat);
        check("add_after_rst", r, 32'd3);

        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 2))
                0: begin ra = $urandom; rb = $urandom; end
                1: begin ra = 32'($urandom_range(0, 20)); rb = 32'($urandom_range(0, 20)); end
                default: begin ra = edge_vals[$urandom_range(0, 4)]; rb = edge_vals[$urandom_range(0, 4)]; end
            endcase
            do_op(2'($urandom_range(0, 3)), ra, rb, 1'($urandom_range(0, 1)), $urandom_range(0, 3), r, f, lat);
        end

        repeat (5) @(posedge clk);
        #1;
        check("queue_drained", 64'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
